uart_frame_packer: RTL and testbench

UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

---
 rtl/fda_frame_pkg.sv | 23 ++
 rtl/uart_frame_packer.sv | 166 ++++++++++++++++
 tb/tb_uart_frame_packer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fda_frame_pkg.sv
// ---------------------------------------------------------------------------
// fda_frame_pkg
// Shared definitions for the UART frame packer: FSM state enumeration,
// default sync byte and the fixed header length (sync + 2 length bytes).
// ---------------------------------------------------------------------------
package fda_frame_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    LEN_H,
    LEN_L,
    RD_REQ,
    RD_WAIT,
    DATA,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_LEN       = 3;

endpackage

// File: rtl/uart_frame_packer.sv
// ---------------------------------------------------------------------------
// uart_frame_packer
// Reads payload bytes from a storage FIFO and emits a framed byte stream to
// a UART transmitter: SYNC_BYTE, length[15:8], length[7:0], payload bytes,
// and (optionally) a modulo-256 checksum over the length and payload bytes.
//
// Build option:
//   FRAME_CHECKSUM_EN  defined   -> a checksum byte is appended (CSUM state)
//                      undefined -> frame ends after the last payload byte
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start_en     level, permits a new frame to begin
//   payload_len  payload bytes per frame, latched at frame start
//   data_ready   FIFO not empty
//   data_in      FIFO read data, valid one cycle after data_rd
//   data_rd      single-cycle FIFO read strobe
//   tx_data      byte to transmitter
//   tx_valid     tx_data valid
//   tx_ready     transmitter accepts byte
//   abort        pulse, terminates the current frame
//   busy         high whenever not IDLE
//   frame_done   one-cycle pulse after the last byte is accepted
//   frame_count  completed frames, wraps 255->0
// ---------------------------------------------------------------------------
module uart_frame_packer
  import fda_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_en,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             data_ready,
  input  logic [7:0]       data_in,
  output logic             data_rd,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             abort,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_hold;
  logic [15:0]      w_len16;
  logic             w_xfer;
  logic             w_start;
  logic             w_last;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  // The header always carries a 16-bit length regardless of LEN_W.
  assign w_len16 = 16'(r_len);
  assign w_xfer  = tx_valid && tx_ready;
  // abort in the same IDLE cycle wins over a start request.
  assign w_start = start_en && data_ready && (payload_len != '0) && !abort;
  assign w_last  = (r_rem == LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start)    w_next = SYNC;
        SYNC:    if (w_xfer)     w_next = LEN_H;
        LEN_H:   if (w_xfer)     w_next = LEN_L;
        LEN_L:   if (w_xfer)     w_next = RD_REQ;
        RD_REQ:  if (data_ready) w_next = RD_WAIT;
        RD_WAIT:                 w_next = DATA;
        DATA: begin
          if (w_xfer) begin
`ifdef FRAME_CHECKSUM_EN
            w_next = w_last ? CSUM : RD_REQ;
`else
            w_next = w_last ? DONE : RD_REQ;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM:    if (w_xfer)     w_next = DONE;
`endif
        DONE:                    w_next = IDLE;
        default:                 w_next = IDLE;
      endcase
    end
  end

  // Output logic; in IDLE (and therefore during reset) all outputs are zero.
  always_comb begin
    data_rd    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      SYNC:    begin tx_valid = 1'b1; tx_data = SYNC_BYTE;      end
      LEN_H:   begin tx_valid = 1'b1; tx_data = w_len16[15:8];  end
      LEN_L:   begin tx_valid = 1'b1; tx_data = w_len16[7:0];   end
      // Only one read is ever outstanding: RD_REQ is left on the strobe edge
      // and not re-entered until the held byte has been transferred.
      RD_REQ:  data_rd = data_ready;
      DATA:    begin tx_valid = 1'b1; tx_data = r_hold;         end
`ifdef FRAME_CHECKSUM_EN
      CSUM:    begin tx_valid = 1'b1; tx_data = r_csum;         end
`endif
      DONE:    frame_done = !abort;
      default: ;
    endcase
  end

  // Length, remaining count, checksum and frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_rem       <= '0;
      frame_count <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      if (r_state == IDLE && w_start) begin
        r_len <= payload_len;
        r_rem <= payload_len;
`ifdef FRAME_CHECKSUM_EN
        r_csum <= 8'h00;
`endif
      end
      if (r_state == DATA && w_xfer) begin
        r_rem <= r_rem - LEN_W'(1);
      end
`ifdef FRAME_CHECKSUM_EN
      // The sync byte is excluded from the checksum.
      if (w_xfer && (r_state == LEN_H || r_state == LEN_L || r_state == DATA)) begin
        r_csum <= r_csum + tx_data;
      end
`endif
      if (r_state == DONE && !abort) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Holding register for the byte returned by the FIFO read.
  always_ff @(posedge clk) begin
    if (r_state == RD_WAIT) r_hold <= data_in;
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
module tb_uart_frame_packer;
  import fda_frame_pkg::HDR_LEN;

`ifdef FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_en;
  logic [15:0] payload_len;
  logic        data_ready;
  logic [7:0]  data_in;
  logic        data_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        abort;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  uart_frame_packer #(.SYNC_BYTE(8'hA5), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start_en(start_en), .payload_len(payload_len),
    .data_ready(data_ready), .data_in(data_in), .data_rd(data_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .abort(abort),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  logic [7:0] fifo[$];
  logic [7:0] got[$];
  int  nvec = 0, nerr = 0;
  int  done_cnt = 0, rd_cnt = 0;
  int  exp_fc = 0;
  bit  hold_dr = 0;
  bit  stab_pend = 0;
  logic [7:0] stab_val = 8'h00;

  typedef struct {
    int len; int pct; int gap_at; int gap_len; int stall_at; int stall_len;
    bit incr; int exp_nbytes;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd_dr();
    data_ready = (fifo.size() != 0) && !hold_dr;
  endtask

  // One clock: sample outputs late in the cycle, run the protocol checks,
  // then model the FIFO and the transmitter at the edge.
  task automatic cyc();
    logic s_rd, s_v, s_r, s_fd, s_ab;
    logic [7:0] s_d;
    #3;
    s_rd = data_rd; s_v = tx_valid; s_r = tx_ready; s_fd = frame_done;
    s_d = tx_data; s_ab = abort;
    if (s_rd) chk("rd_needs_ready", data_ready, 1);
    if (stab_pend) begin
      chk("stall_valid", s_v, 1);
      chk("stall_data", s_d, stab_val);
    end
    stab_pend = s_v && !s_r && !s_ab;
    stab_val  = s_d;
    @(posedge clk); #1;
    if (s_rd) begin
      rd_cnt++;
      if (fifo.size() > 0) data_in = fifo.pop_front();
    end
    if (s_v && s_r) got.push_back(s_d);
    if (s_fd) done_cnt++;
    upd_dr();
  endtask

  // Send one frame and compare the whole tx stream with the model.
  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] exp[$];
    logic [7:0] cs, p;
    logic [15:0] l16;
    int rd0, d0, gapc, stc, budget;
    l16 = v.len[15:0];
    exp.push_back(8'hA5); exp.push_back(l16[15:8]); exp.push_back(l16[7:0]);
    cs = l16[15:8] + l16[7:0];
    for (int k = 0; k < v.len; k++) begin
      p = v.incr ? 8'(k + 1) : 8'($urandom);
      fifo.push_back(p); exp.push_back(p); cs = cs + p;
    end
    if (CS == 1) exp.push_back(cs);
    got.delete();
    upd_dr();
    payload_len = l16; start_en = 1'b1;
    rd0 = rd_cnt; d0 = done_cnt; gapc = 0; stc = 0;
    budget = 6 * v.len + v.gap_len + v.stall_len + 200;
    for (int c = 0; c < budget; c++) begin
      tx_ready = ($urandom_range(0, 99) < v.pct);
      hold_dr  = (v.gap_len > 0 && got.size() == 3 + v.gap_at && gapc < v.gap_len);
      if (hold_dr) gapc++;
      upd_dr();
      #1;
      if (hold_dr) begin
        chk({tag, "_gap_rd"}, data_rd, 0);
        chk({tag, "_gap_busy"}, busy, 1);
      end
      if (v.stall_len > 0 && got.size() == v.stall_at && tx_valid && stc < v.stall_len) begin
        tx_ready = 1'b0; stc++;
        chk({tag, "_stall_byte"}, tx_data, exp[v.stall_at]);
      end
      cyc();
      if (c == 0) begin
        start_en = 1'b0;
        payload_len = 16'($urandom);  // must not affect the running frame
      end
      if (done_cnt != d0) break;
    end
    hold_dr = 0; tx_ready = 1'b1;
    chk({tag, "_idle_after"}, busy, 0);
    exp_fc = (exp_fc + 1) % 256;
    chk({tag, "_count"}, frame_count, exp_fc);
    cyc();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_nbytes"}, got.size(), exp.size());
    chk({tag, "_nbytes_tbl"}, got.size(), v.exp_nbytes);
    chk({tag, "_nreads"}, rd_cnt - rd0, v.len);
    chk({tag, "_stalls"}, stc, v.stall_len);
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] != exp[i]) chk({tag, "_byte"}, got[i], exp[i]);
      else nvec++;
    fifo.delete(); upd_dr();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [7:0] lit[$];
    int d0, rd0;

    tbl[0] = '{len:4,   pct:100, gap_at:0, gap_len:0,  stall_at:0, stall_len:0, incr:1, exp_nbytes:7 + CS};
    tbl[1] = '{len:4,   pct:100, gap_at:0, gap_len:0,  stall_at:4, stall_len:5, incr:1, exp_nbytes:7 + CS};
    tbl[2] = '{len:6,   pct:100, gap_at:2, gap_len:10, stall_at:0, stall_len:0, incr:0, exp_nbytes:9 + CS};
    tbl[3] = '{len:1,   pct:100, gap_at:0, gap_len:0,  stall_at:0, stall_len:0, incr:0, exp_nbytes:4 + CS};
    tbl[4] = '{len:300, pct:100, gap_at:0, gap_len:0,  stall_at:0, stall_len:0, incr:0, exp_nbytes:303 + CS};
    tbl[5] = '{len:9,   pct:40,  gap_at:0, gap_len:0,  stall_at:0, stall_len:0, incr:0, exp_nbytes:12 + CS};

    reset_n = 1'b0; start_en = 1'b0; payload_len = 16'h0; data_ready = 1'b0;
    data_in = 8'h00; tx_ready = 1'b1; abort = 1'b0;
    #12;
    chk("rst_busy", busy, 0);       chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0); chk("rst_data_rd", data_rd, 0);
    chk("rst_done", frame_done, 0); chk("rst_count", frame_count, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    // Exact stream for the reference frame
    run_frame(tbl[0], "ref");
    lit = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CS == 1) lit.push_back(8'h0E);
    chk("ref_len", got.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got.size(); i++) chk("ref_stream", got[i], lit[i]);

    for (int t = 1; t < 6; t++) run_frame(tbl[t], $sformatf("tbl%0d", t));

    // payload_len = 0 never starts a frame
    fifo.push_back(8'h55); upd_dr(); payload_len = 16'h0; start_en = 1'b1;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) cyc();
    chk("len0_busy", busy, 0); chk("len0_reads", rd_cnt - rd0, 0);
    start_en = 1'b0;

    // abort together with a start request stays in IDLE
    payload_len = 16'd3; start_en = 1'b1; abort = 1'b1;
    cyc();
    abort = 1'b0; start_en = 1'b0;
    chk("abort_start_busy", busy, 0);
    cyc();
    chk("abort_start_busy2", busy, 0);
    fifo.delete(); upd_dr();

    // abort while payload byte 3 of 8 is presented
    for (int k = 0; k < 8; k++) fifo.push_back(8'(8'h30 + k));
    got.delete(); upd_dr(); payload_len = 16'd8; start_en = 1'b1; tx_ready = 1'b1;
    d0 = done_cnt;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (got.size() == 5 && tx_valid) break;
      cyc(); start_en = 1'b0;
    end
    chk("abort_reached_b3", tx_data, 8'h32);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_tx_valid", tx_valid, 0);
    chk("abort_count", frame_count, exp_fc);
    fifo.delete(); upd_dr();
    for (int i = 0; i < 5; i++) cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    v = tbl[3]; run_frame(v, "post_abort");

    // randomized frames against the model
    for (int r = 0; r < 20; r++) begin
      v.len = $urandom_range(1, 12); v.pct = $urandom_range(40, 100);
      v.gap_at = $urandom_range(0, v.len - 1); v.gap_len = $urandom_range(0, 6);
      v.stall_at = 0; v.stall_len = 0; v.incr = 0; v.exp_nbytes = v.len + HDR_LEN + CS;
      run_frame(v, $sformatf("rnd%0d", r));
    end

    // back-to-back single-byte frames: the counter wraps
    v = tbl[3];
    for (int f = 0; f < 256; f++) run_frame(v, "wrap");
    chk("wrap_same", frame_count, exp_fc);

    // reset in the middle of a frame takes effect without a clock edge
    for (int k = 0; k < 5; k++) fifo.push_back(8'(k));
    upd_dr(); payload_len = 16'd5; start_en = 1'b1; d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin cyc(); start_en = 1'b0; end
    chk("midrst_was_busy", busy, 1);
    #2; reset_n = 1'b0; #1;
    chk("midrst_busy", busy, 0);        chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 0);  chk("midrst_data_rd", data_rd, 0);
    chk("midrst_done", frame_done, 0);  chk("midrst_count", frame_count, 0);
    exp_fc = 0; stab_pend = 0;
    @(posedge clk); #1; reset_n = 1'b1;
    fifo.delete(); upd_dr();
    for (int i = 0; i < 10; i++) cyc();
    chk("midrst_no_done", done_cnt - d0, 0);
    run_frame(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
